// File: rtl/exe_stage_pkg.sv
// Shared definitions for the execute stage: ALU command codes, shift types,
// FSM state encoding, NZCV bit positions and the Val2 operand generator.
package arm_exe_pkg;

  // ALU command codes as produced by decode
  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_MVN = 4'b1001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;
  localparam logic [3:0] EXE_MUL = 4'b1010;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_t;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MUL_RUN = 1'b1
  } exe_state_t;

  // Bit positions inside the 4-bit NZCV status register
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Rotate right by 0..31; duplicating the word makes amount 0 a pass-through
  function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] amt);
    logic [63:0] tmp;
    tmp = {x, x} >> amt;
    return tmp[31:0];
  endfunction

  // Second ALU operand: rotated immediate, memory offset or shifted Rm
  function automatic logic [31:0] gen_val2(input logic imm, input logic mem,
                                           input logic [31:0] rm, input logic [11:0] so);
    logic [31:0] v;
    if (imm) begin
      v = ror32({24'd0, so[7:0]}, {so[11:8], 1'b0});
    end else if (mem) begin
      v = {20'd0, so};
    end else begin
      case (shift_t'(so[6:5]))
        SH_LSL:  v = rm << so[11:7];
        SH_LSR:  v = rm >> so[11:7];
        SH_ASR:  v = 32'($signed(rm) >>> so[11:7]);
        SH_ROR:  v = ror32(rm, so[11:7]);
        default: v = rm;
      endcase
    end
    return v;
  endfunction

endpackage

// File: rtl/exe_stage_if.sv
// Decode-to-execute bundle plus the execute-side feedback (stall, branch, NZCV).
// master = decode stage, slave = execute stage.
interface exe_stage_if;
  logic        valid_in;
  logic        wb_en;
  logic        mem_r_en;
  logic        mem_w_en;
  logic        b;
  logic        s;
  logic [3:0]  exe_cmd;
  logic [31:0] val_rn;
  logic [31:0] val_rm;
  logic        imm;
  logic [11:0] shift_operand;
  logic [23:0] signed_imm_24;
  logic [3:0]  dest;
  logic [31:0] pc_in;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic [3:0]  sr;

  modport master (
    output valid_in, wb_en, mem_r_en, mem_w_en, b, s, exe_cmd, val_rn, val_rm,
           imm, shift_operand, signed_imm_24, dest, pc_in,
    input  stall, branch_taken, branch_addr, sr
  );

  modport slave (
    input  valid_in, wb_en, mem_r_en, mem_w_en, b, s, exe_cmd, val_rn, val_rm,
           imm, shift_operand, signed_imm_24, dest, pc_in,
    output stall, branch_taken, branch_addr, sr
  );
endinterface

// File: rtl/exe_multiplier.sv
// Iterative shift-add multiplier, BITS multiplier bits retired per cycle.
// done is raised during the final iteration cycle and result is valid in that
// same cycle (the last partial product is added combinationally).
module exe_multiplier #(
  parameter int BITS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);
  localparam int ITERS = 32 / BITS;
  localparam int CNT_W = 5;

  logic [31:0]      mcand_q, mcand_d;
  logic [31:0]      mplier_q, mplier_d;
  logic [31:0]      acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [31:0]      pp_s;
  logic [31:0]      acc_next_s;
  logic             last_s;

  // Partial product of the current multiplier chunk and next-state selection
  always_comb begin
    pp_s = 32'd0;
    for (int i = 0; i < BITS; i++) begin
      pp_s = pp_s + (mplier_q[i] ? (mcand_q << i) : 32'd0);
    end
    acc_next_s = acc_q + pp_s;
    last_s     = busy_q && (cnt_q == CNT_W'(ITERS - 1));
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    if (start) begin
      mcand_d  = a;
      mplier_d = b;
      acc_d    = 32'd0;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      mcand_d  = mcand_q << BITS;
      mplier_d = mplier_q >> BITS;
      acc_d    = acc_next_s;
      cnt_d    = cnt_q + 1'b1;
      busy_d   = ~last_s;
    end else begin
      busy_d   = 1'b0;
    end
  end

  // Iteration state, cleared by synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      mcand_q  <= 32'd0;
      mplier_q <= 32'd0;
      acc_q    <= 32'd0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

  assign busy   = busy_q;
  assign done   = last_s;
  assign result = acc_next_s;

endmodule

// File: rtl/exe_stage.sv
// Execute stage: Val2 generation, ALU, branch target, NZCV update and the
// EXE/MEM boundary register. Define EXE_FAST_MUL_EN for a single-cycle
// combinational multiply (no FSM, stall tied low).
module exe_stage
  import arm_exe_pkg::*;
#(
  parameter int MUL_BITS_PER_ITER = 2
) (
  input  logic        clk,
  input  logic        rst,
  exe_stage_if.slave  dec,
  output logic [31:0] alu_result_o,
  output logic [31:0] val_rm_o,
  output logic [3:0]  dest_o,
  output logic        wb_en_o,
  output logic        mem_r_en_o,
  output logic        mem_w_en_o
);
  logic [31:0] alu_result_q, alu_result_d;
  logic [31:0] val_rm_q, val_rm_d;
  logic [3:0]  dest_q, dest_d;
  logic        wb_en_q, wb_en_d;
  logic        mem_r_en_q, mem_r_en_d;
  logic        mem_w_en_q, mem_w_en_d;
  logic [3:0]  sr_q, sr_d;

  logic [31:0] val2_s, opb_s, alu_res_s, mul_res_s;
  logic [32:0] sum_s;
  logic        cin_s, arith_s, c_s, v_s, capture_s, stall_s;
  logic [3:0]  alu_nzcv_s;

`ifdef EXE_FAST_MUL_EN
  assign mul_res_s = dec.val_rn * dec.val_rm;
  assign stall_s   = 1'b0;
`else
  exe_state_t  state_q, state_d;
  logic        mul_start_s, mul_busy_s, mul_done_s;

  exe_multiplier #(.BITS(MUL_BITS_PER_ITER)) u_mul (
    .clk    (clk),
    .rst    (rst),
    .start  (mul_start_s),
    .a      (dec.val_rn),
    .b      (dec.val_rm),
    .busy   (mul_busy_s),
    .done   (mul_done_s),
    .result (mul_res_s)
  );

  // Decode holds its bundle from MUL acceptance until the final iteration
  assign stall_s = rst && (((state_q == ST_IDLE) && dec.valid_in && (dec.exe_cmd == EXE_MUL)) ||
                           ((state_q == ST_MUL_RUN) && mul_busy_s && !mul_done_s));
`endif

  // Val2, shared adder (subtract as add of inverted operand) and NZCV result
  always_comb begin
    val2_s  = gen_val2(dec.imm, dec.mem_r_en | dec.mem_w_en, dec.val_rm, dec.shift_operand);
    arith_s = 1'b0;
    opb_s   = val2_s;
    cin_s   = 1'b0;
    case (dec.exe_cmd)
      EXE_ADD: begin arith_s = 1'b1; opb_s = val2_s;  cin_s = 1'b0;         end
      EXE_ADC: begin arith_s = 1'b1; opb_s = val2_s;  cin_s = sr_q[FLAG_C]; end
      EXE_SUB: begin arith_s = 1'b1; opb_s = ~val2_s; cin_s = 1'b1;         end
      EXE_SBC: begin arith_s = 1'b1; opb_s = ~val2_s; cin_s = sr_q[FLAG_C]; end
      default: begin arith_s = 1'b0; opb_s = val2_s;  cin_s = 1'b0;         end
    endcase
    sum_s = {1'b0, dec.val_rn} + {1'b0, opb_s} + {32'd0, cin_s};
    case (dec.exe_cmd)
      EXE_MOV: alu_res_s = val2_s;
      EXE_MVN: alu_res_s = ~val2_s;
      EXE_AND: alu_res_s = dec.val_rn & val2_s;
      EXE_ORR: alu_res_s = dec.val_rn | val2_s;
      EXE_EOR: alu_res_s = dec.val_rn ^ val2_s;
      EXE_MUL: alu_res_s = mul_res_s;
      default: alu_res_s = arith_s ? sum_s[31:0] : 32'd0;
    endcase
    if (arith_s) begin
      c_s = sum_s[32];
      v_s = (dec.val_rn[31] == opb_s[31]) && (sum_s[31] != dec.val_rn[31]);
    end else begin
      c_s = sr_q[FLAG_C];
      v_s = sr_q[FLAG_V];
    end
    alu_nzcv_s = {alu_res_s[31], (alu_res_s == 32'd0), c_s, v_s};
  end

  // Next state of the EXE/MEM register, status register and MUL sequencing
  always_comb begin
    alu_result_d = 32'd0;
    val_rm_d     = 32'd0;
    dest_d       = 4'd0;
    wb_en_d      = 1'b0;
    mem_r_en_d   = 1'b0;
    mem_w_en_d   = 1'b0;
    sr_d         = sr_q;
`ifdef EXE_FAST_MUL_EN
    capture_s    = dec.valid_in;
`else
    state_d      = state_q;
    mul_start_s  = 1'b0;
    capture_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (dec.valid_in && (dec.exe_cmd == EXE_MUL)) begin
          mul_start_s = 1'b1;
          state_d     = ST_MUL_RUN;
        end else begin
          capture_s   = dec.valid_in;
        end
      end
      ST_MUL_RUN: begin
        if (mul_done_s) begin
          capture_s = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          capture_s = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
`endif
    if (capture_s) begin
      alu_result_d = alu_res_s;
      val_rm_d     = dec.val_rm;
      dest_d       = dec.dest;
      wb_en_d      = dec.wb_en;
      mem_r_en_d   = dec.mem_r_en;
      mem_w_en_d   = dec.mem_w_en;
      if (dec.s) begin
        sr_d = alu_nzcv_s;
      end else begin
        sr_d = sr_q;
      end
    end else begin
      wb_en_d = 1'b0;
    end
  end

  // Registered EXE/MEM outputs, NZCV and FSM state with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      alu_result_q <= 32'd0;
      val_rm_q     <= 32'd0;
      dest_q       <= 4'd0;
      wb_en_q      <= 1'b0;
      mem_r_en_q   <= 1'b0;
      mem_w_en_q   <= 1'b0;
      sr_q         <= 4'd0;
`ifndef EXE_FAST_MUL_EN
      state_q      <= ST_IDLE;
`endif
    end else begin
      alu_result_q <= alu_result_d;
      val_rm_q     <= val_rm_d;
      dest_q       <= dest_d;
      wb_en_q      <= wb_en_d;
      mem_r_en_q   <= mem_r_en_d;
      mem_w_en_q   <= mem_w_en_d;
      sr_q         <= sr_d;
`ifndef EXE_FAST_MUL_EN
      state_q      <= state_d;
`endif
    end
  end

  assign alu_result_o     = alu_result_q;
  assign val_rm_o         = val_rm_q;
  assign dest_o           = dest_q;
  assign wb_en_o          = wb_en_q;
  assign mem_r_en_o       = mem_r_en_q;
  assign mem_w_en_o       = mem_w_en_q;
  assign dec.sr           = sr_q;
  assign dec.stall        = stall_s;
  assign dec.branch_taken = dec.valid_in & dec.b & ~stall_s;
  assign dec.branch_addr  = dec.pc_in + {{6{dec.signed_imm_24[23]}}, dec.signed_imm_24, 2'b00};

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: directed cases followed by random
// instructions checked against a behavioural model of the execute rules.
module tb_exe_stage;
  import arm_exe_pkg::*;

  localparam int     MUL_ITERS = 32 / 2;
  localparam longint TWO32     = 64'sd4294967296;
  localparam longint MAXS      = 64'sd2147483647;
  localparam longint MINS      = -64'sd2147483648;

  typedef struct {
    logic        valid, wb, mr, mw, b, s, imm;
    logic [3:0]  cmd, dest;
    logic [31:0] rn, rm, pc;
    logic [11:0] so;
    logic [23:0] off;
  } ins_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] alu_result_o, val_rm_o;
  logic [3:0]  dest_o;
  logic        wb_en_o, mem_r_en_o, mem_w_en_o;
  int          n_checks = 0;
  int          n_errs   = 0;
  logic [3:0]  m_sr     = 4'd0;
  logic [3:0]  alu_cmds [9] = '{EXE_MOV, EXE_MVN, EXE_ADD, EXE_ADC, EXE_SUB,
                                EXE_SBC, EXE_AND, EXE_ORR, EXE_EOR};

  exe_stage_if dif ();

  exe_stage #(.MUL_BITS_PER_ITER(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .dec          (dif.slave),
    .alu_result_o (alu_result_o),
    .val_rm_o     (val_rm_o),
    .dest_o       (dest_o),
    .wb_en_o      (wb_en_o),
    .mem_r_en_o   (mem_r_en_o),
    .mem_w_en_o   (mem_w_en_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic ins_t nop();
    ins_t n = '{default: '0};
    return n;
  endfunction

  task automatic drive(input ins_t t);
    dif.valid_in      = t.valid;
    dif.wb_en         = t.wb;
    dif.mem_r_en      = t.mr;
    dif.mem_w_en      = t.mw;
    dif.b             = t.b;
    dif.s             = t.s;
    dif.exe_cmd       = t.cmd;
    dif.val_rn        = t.rn;
    dif.val_rm        = t.rm;
    dif.imm           = t.imm;
    dif.shift_operand = t.so;
    dif.signed_imm_24 = t.off;
    dif.dest          = t.dest;
    dif.pc_in         = t.pc;
  endtask

  // Val2 by repeated single-bit shifts/rotations
  function automatic logic [31:0] m_val2(input ins_t t);
    logic [31:0] x;
    int n;
    if (t.imm) begin
      x = {24'd0, t.so[7:0]};
      n = 2 * int'(t.so[11:8]);
      for (int i = 0; i < n; i++) x = {x[0], x[31:1]};
    end else if (t.mr || t.mw) begin
      x = {20'd0, t.so};
    end else begin
      x = t.rm;
      n = int'(t.so[11:7]);
      for (int i = 0; i < n; i++) begin
        case (t.so[6:5])
          2'd0:    x = {x[30:0], 1'b0};
          2'd1:    x = {1'b0, x[31:1]};
          2'd2:    x = {x[31], x[31:1]};
          default: x = {x[0], x[31:1]};
        endcase
      end
    end
    return x;
  endfunction

  // Result and new NZCV from wide integer arithmetic
  task automatic m_exec(input ins_t t, input logic [3:0] sr_in,
                        output logic [31:0] res, output logic [3:0] sr_out);
    longint a, bv, sa, sb, r, sr, cin;
    logic c, v;
    logic [31:0] v2;
    v2  = m_val2(t);
    a   = longint'(t.rn);
    sa  = longint'($signed(t.rn));
    bv  = longint'(v2);
    sb  = longint'($signed(v2));
    cin = sr_in[1] ? 64'sd1 : 64'sd0;
    c   = sr_in[1];
    v   = sr_in[0];
    res = 32'd0;
    case (t.cmd)
      EXE_MOV: res = v2;
      EXE_MVN: res = ~v2;
      EXE_AND: res = t.rn & v2;
      EXE_ORR: res = t.rn | v2;
      EXE_EOR: res = t.rn ^ v2;
      EXE_MUL: begin r = longint'(t.rn) * longint'(t.rm); res = 32'(r); end
      EXE_ADD, EXE_ADC: begin
        if (t.cmd == EXE_ADD) cin = 64'sd0;
        r = a + bv + cin; sr = sa + sb + cin;
        res = 32'(r); c = (r >= TWO32); v = (sr > MAXS) || (sr < MINS);
      end
      EXE_SUB, EXE_SBC: begin
        cin = (t.cmd == EXE_SUB) ? 64'sd0 : (64'sd1 - cin);
        r = a - bv - cin; sr = sa - sb - cin;
        res = 32'(r); c = (a >= bv + cin); v = (sr > MAXS) || (sr < MINS);
      end
      default: res = 32'd0;
    endcase
    sr_out = t.s ? {res[31], (res == 32'd0), c, v} : sr_in;
  endtask

  task automatic run_alu(input ins_t t);
    logic [31:0] er, eaddr;
    logic [3:0]  esr;
    int off;
    drive(t);
    #1;
    chk("stall_low", 32'(dif.stall), 32'd0);
    chk("br_taken", 32'(dif.branch_taken), 32'(t.valid & t.b));
    off = int'(t.off);
    if (off >= 8388608) off = off - 16777216;
    eaddr = t.pc + 32'(off * 4);
    chk("br_addr", dif.branch_addr, eaddr);
    m_exec(t, m_sr, er, esr);
    tick();
    if (t.valid) begin
      chk("alu_result", alu_result_o, er);
      chk("val_rm_o", val_rm_o, t.rm);
      chk("dest_o", 32'(dest_o), 32'(t.dest));
      chk("wb_en_o", 32'(wb_en_o), 32'(t.wb));
      chk("mem_en_o", 32'({mem_r_en_o, mem_w_en_o}), 32'({t.mr, t.mw}));
      m_sr = esr;
    end else begin
      chk("bubble_en", 32'({wb_en_o, mem_r_en_o, mem_w_en_o}), 32'd0);
    end
    chk("sr", 32'(dif.sr), 32'(m_sr));
  endtask

  task automatic run_mul(input ins_t t);
    int cyc;
    logic bub;
    logic [31:0] er;
    logic [3:0]  esr;
    drive(t);
    #1;
    cyc = 0;
    bub = 1'b0;
    while (dif.stall === 1'b1 && cyc < 100) begin
      tick();
      cyc++;
      bub = bub | wb_en_o | mem_r_en_o | mem_w_en_o;
    end
    chk("mul_stall_cycles", 32'(cyc), 32'(MUL_ITERS));
    chk("mul_bubbles", 32'(bub), 32'd0);
    m_exec(t, m_sr, er, esr);
    tick();
    chk("mul_result", alu_result_o, er);
    chk("mul_wb_en", 32'(wb_en_o), 32'(t.wb));
    chk("mul_dest", 32'(dest_o), 32'(t.dest));
    m_sr = esr;
    chk("mul_sr", 32'(dif.sr), 32'(m_sr));
    drive(nop());
  endtask

  initial begin
    ins_t t;
    logic any;

    // Reset with a MUL presented: stall must stay low, outputs cleared
    t = nop(); t.valid = 1'b1; t.cmd = EXE_MUL; t.rn = 32'd3; t.rm = 32'd4; t.wb = 1'b1;
    drive(t);
    #1;
    chk("rst_stall", 32'(dif.stall), 32'd0);
    tick(); tick();
    chk("rst_alu", alu_result_o, 32'd0);
    chk("rst_en", 32'({wb_en_o, mem_r_en_o, mem_w_en_o}), 32'd0);
    chk("rst_sr", 32'(dif.sr), 32'd0);
    chk("rst_stall2", 32'(dif.stall), 32'd0);
    m_sr = 4'd0;
    drive(nop());
    rst = 1'b1;
    tick();

    // ADD overflow into the sign bit
    t = nop(); t.valid = 1'b1; t.cmd = EXE_ADD; t.s = 1'b1; t.wb = 1'b1; t.dest = 4'd3;
    t.rn = 32'h7FFF_FFFF; t.imm = 1'b1; t.so = 12'h001;
    run_alu(t);
    chk("add_ovf_res", alu_result_o, 32'h8000_0000);
    chk("add_ovf_sr", 32'(dif.sr), 32'b1001);

    // SUB equal operands, register operand with zero shift
    t = nop(); t.valid = 1'b1; t.cmd = EXE_SUB; t.s = 1'b1; t.rn = 32'd5; t.rm = 32'd5;
    run_alu(t);
    chk("sub_zero_res", alu_result_o, 32'd0);
    chk("sub_zero_sr", 32'(dif.sr), 32'b0110);

    // MOV of 0xFF rotated right by 4
    t = nop(); t.valid = 1'b1; t.cmd = EXE_MOV; t.wb = 1'b1; t.imm = 1'b1; t.so = 12'h2FF;
    run_alu(t);
    chk("mov_rot_res", alu_result_o, 32'hF000_000F);

    // Backward branch target, same cycle
    t = nop(); t.valid = 1'b1; t.b = 1'b1; t.pc = 32'h100; t.off = 24'hFFFFFE;
    drive(t);
    #1;
    chk("branch_taken", 32'(dif.branch_taken), 32'd1);
    chk("branch_addr", dif.branch_addr, 32'h0000_00F8);
    run_alu(t);

    // MUL whose product lives entirely in the high word
    t = nop(); t.valid = 1'b1; t.cmd = EXE_MUL; t.wb = 1'b1; t.dest = 4'd7;
    t.rn = 32'h0001_0000; t.rm = 32'h0003_0000;
    run_mul(t);
    chk("mul_hi_res", alu_result_o, 32'd0);
    chk("mul_hi_wb", 32'(wb_en_o), 32'd1);

    // Reset in the middle of a MUL aborts it
    t = nop(); t.valid = 1'b1; t.cmd = EXE_MUL; t.wb = 1'b1; t.s = 1'b1; t.rn = 32'd7; t.rm = 32'd6;
    drive(t);
    repeat (5) tick();
    rst = 1'b0;
    #1;
    chk("abort_stall", 32'(dif.stall), 32'd0);
    tick();
    chk("abort_alu", alu_result_o, 32'd0);
    chk("abort_en", 32'({wb_en_o, mem_r_en_o, mem_w_en_o}), 32'd0);
    chk("abort_sr", 32'(dif.sr), 32'd0);
    m_sr = 4'd0;
    rst = 1'b1;
    t = nop(); t.valid = 1'b1; t.cmd = EXE_ADD; t.wb = 1'b1; t.dest = 4'd2; t.rn = 32'd1; t.rm = 32'd2;
    run_alu(t);
    chk("after_abort_add", alu_result_o, 32'd3);
    drive(nop());
    any = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      any = any | wb_en_o | mem_r_en_o | mem_w_en_o;
    end
    chk("abort_no_result", 32'(any), 32'd0);

    // Random instruction stream against the model
    for (int i = 0; i < 300; i++) begin
      t       = nop();
      t.valid = ($urandom_range(0, 7) != 0);
      t.cmd   = ($urandom_range(0, 7) == 0) ? EXE_MUL : alu_cmds[$urandom_range(0, 8)];
      t.wb    = 1'($urandom);
      t.s     = 1'($urandom);
      t.b     = 1'($urandom);
      t.imm   = 1'($urandom);
      t.mr    = ($urandom_range(0, 5) == 0);
      t.mw    = ($urandom_range(0, 5) == 0);
      t.dest  = 4'($urandom);
      t.rn    = ($urandom_range(0, 4) == 0) ? 32'h8000_0000 - 32'($urandom_range(0, 2)) : $urandom;
      t.rm    = ($urandom_range(0, 4) == 0) ? t.rn : $urandom;
      t.so    = 12'($urandom);
      t.off   = 24'($urandom);
      t.pc    = $urandom & 32'hFFFF_FFFC;
      if (t.valid && t.cmd == EXE_MUL) run_mul(t);
      else run_alu(t);
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage directly downstream of the decode stage; consumes its decoded control and operand bundle.
- Generates Val2 (immediate rotate / register shift / memory offset), runs the ALU, computes the branch target and updates the NZCV status register.
- Multiply is iterative and stalls decode via a busy handshake.
- Results are registered into the EXE/MEM boundary register owned by this block.

Parameters:
- MUL_BITS_PER_ITER, 2, multiplier bits retired per iteration; legal values 1, 2, 4.
- MUL_ITERS = 32/MUL_BITS_PER_ITER, derived (16 at default), not overridable.

Ports:
- clk  in  1  clock
- rst  in  1  reset; active-low, synchronous
- valid_in  in  1  decode bundle valid
- wb_en, mem_r_en, mem_w_en, b, s  in  1 each  decoded control bits
- exe_cmd  in  4  ALU command
- val_rn, val_rm  in  32 each  register operands
- imm  in  1  Val2 is a rotated immediate
- shift_operand  in  12  shifter field
- signed_imm_24  in  24  branch offset
- dest  in  4  destination register
- pc_in  in  32  PC+4 of this instruction
- stall  out  1  decode must hold its bundle stable
- branch_taken  out  1  combinational: valid_in & b & ~stall
- branch_addr  out  32  combinational: pc_in + (sext(signed_imm_24) << 2)
- sr  out  4  NZCV status register, feeds decode condition check
- alu_result_o, val_rm_o  out  32 each  registered
- dest_o  out  4  registered
- wb_en_o, mem_r_en_o, mem_w_en_o  out  1 each  registered

Behaviour:
- Reset (rst==0 at a clk edge): all registered outputs 0, sr=0, FSM IDLE, multiplier cleared. While rst==0, stall is forced 0.
- Val2 selection:
  - imm=1: {24'b0, shift_operand[7:0]} rotated right by 2*shift_operand[11:8].
  - else if mem_r_en|mem_w_en: zero-extended shift_operand[11:0].
  - else: val_rm shifted by shift_operand[11:7], type shift_operand[6:5] (00 LSL, 01 LSR, 10 ASR, 11 ROR). An amount of 0 passes val_rm unchanged for every type.
- ALU, 32-bit, carry-in = sr.C:
  - MOV=Val2; MVN=~Val2; ADD; ADC; SUB; SBC (rn-Val2-~C); AND; ORR; EOR.
  - CMP/TST reuse the SUB/AND codes with wb_en=0.
  - LDR/STR use ADD.
- Flags:
  - N=result[31]; Z=(result==0).
  - C = carry-out of add, or NOT borrow of sub.
  - V = signed overflow for add/sub.
  - Logic ops and MUL leave C and V unchanged.
  - sr is written only when s=1 on an accepted instruction.
- FSM states: IDLE, MUL_RUN.
  - IDLE, valid_in & exe_cmd==EXE_MUL → MUL_RUN. stall=1 combinationally in that cycle; operands are latched into the multiplier.
  - MUL_RUN counts MUL_ITERS iterations. stall stays 1 until the final iteration cycle, where stall=0 and the low 32 bits of val_rn*val_rm are written to the output register.
  - Net effect: the output register updates at edge MUL_ITERS+1 after acceptance; stall is high for MUL_ITERS cycles. Return to IDLE.
  - While stall=1 the output register loads a bubble (all enables 0).
  - Back-to-back MULs: the second MUL is accepted in the cycle after the first completes.
- Non-MUL, IDLE: 1-cycle latency; the output register captures the bundle each edge.
- valid_in=0: the output register captures a bubble; sr is unchanged.
- valid_in is ignored in MUL_RUN, because the held bundle belongs to the running MUL.
- Reset mid-MUL aborts the operation: no result, no sr write.

Optional Feature:
- EXE_FAST_MUL_EN defined:
  - MUL is a single-cycle combinational multiply; the FSM, multiplier instance and MUL_RUN state are removed.
  - stall is tied to 0; MUL latency is 1 cycle like any ALU op.
- Undefined: iterative behaviour as specified above.

Decomposition:
- Shared package arm_exe_pkg holds:
  - exe_cmd codes: MOV 0001, MVN 1001, ADD 0010, ADC 0011, SUB 0100, SBC 0101, AND 0110, ORR 0111, EOR 1000, EXE_MUL 1010.
  - Shift-type codes, FSM state encoding, NZCV bit indices.
- One sub-module, exe_multiplier: start/busy/done, iterative shift-add of MUL_BITS_PER_ITER bits per cycle, 32-bit result.

Test Plan:
- ADD, s=1, rn=0x7FFFFFFF, imm=1, Val2=1 → alu_result_o=0x80000000 next cycle; sr=1001 (N,V).
- SUB, s=1, rn=5, rm=5, shift amount 0 → result 0; sr NZCV=0110.
- MOV, imm=1, shift_operand=0x2FF (0xFF ROR 4) → alu_result_o=0xF000000F.
- MUL, rn=0x10000, rm=0x30000, default parameter → stall high 16 cycles; at edge 17 alu_result_o=0 (low word), wb_en_o=1; bubbles before.
- MUL 7*6 with rst pulled low at iteration 5 → stall 0 during reset, outputs 0, no result emitted; a following ADD proceeds normally.
- b=1, pc_in=0x100, signed_imm_24=0xFFFFFE → branch_taken=1, branch_addr=0xF8 in the same cycle.
